// File: rtl/fastio_loopback_sequencer_if.sv
// Pad-side signals between the loopback sequencer and the fastio DUT/observation pads.
interface fastio_loopback_sequencer_if;
    logic dut_oe_l_o;
    logic dut_out_l_o;
    logic dut_med_enable_o;
    logic dut_strong_enable_o;
    logic fastio_in_i;

    modport master (
        output dut_oe_l_o, dut_out_l_o, dut_med_enable_o, dut_strong_enable_o,
        input  fastio_in_i
    );
    modport slave (
        input  dut_oe_l_o, dut_out_l_o, dut_med_enable_o, dut_strong_enable_o,
        output fastio_in_i
    );
endinterface

// File: rtl/fastio_loopback_sequencer.sv
// Drives a fastio pad through each selected drive-strength code, toggling it and
// checking the looped-back pad after a settle time; keeps saturating mismatch counts.
//
// state  | meaning
// IDLE   | waiting for start, results held
// SEL    | pick next strength code from remaining mask
// WAIT   | driving level, counting down settle cycles
// SAMPLE | compare synchronized loopback with level, flip level
// DONE   | publish pass flags, pulse done
module fastio_loopback_sequencer #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [7:0]            settle_i,
    input  logic [15:0]           toggles_i,
    input  logic [3:0]            mask_i,
    fastio_loopback_sequencer_if.master pad,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [3:0]            pass_o,
    output logic [4*CNT_W-1:0]    err_count_o
);
    typedef enum logic [2:0] {S_IDLE, S_SEL, S_WAIT, S_SAMPLE, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [7:0]               settle_lat_q, settle_lat_d;
    logic [15:0]              toggles_lat_q, toggles_lat_d;
    logic [3:0]               mask_lat_q, mask_lat_d;
    logic [3:0]               remaining_q, remaining_d;
    logic [1:0]               code_q, code_d;
    logic                     level_q, level_d;
    logic [15:0]              tog_left_q, tog_left_d;
    logic [7:0]               settle_cnt_q, settle_cnt_d;
    logic [3:0][CNT_W-1:0]    err_q, err_d;
    logic [3:0]               pass_q, pass_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     oe_q, oe_d, out_q, out_d, med_q, med_d, strong_q, strong_d;
    logic                     busy_q, busy_d, done_q, done_d;
    logic [1:0]               low_idx;
    logic                     sync_in;
    logic                     drive;

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], pad.fastio_in_i};

    always_comb begin
        low_idx = 2'd0;
        if (remaining_q[0])      low_idx = 2'd0;
        else if (remaining_q[1]) low_idx = 2'd1;
        else if (remaining_q[2]) low_idx = 2'd2;
        else if (remaining_q[3]) low_idx = 2'd3;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q       <= S_IDLE;
            settle_lat_q  <= '0;
            toggles_lat_q <= '0;
            mask_lat_q    <= '0;
            remaining_q   <= '0;
            code_q        <= '0;
            level_q       <= 1'b0;
            tog_left_q    <= '0;
            settle_cnt_q  <= '0;
            err_q         <= '0;
            pass_q        <= '0;
            sync_q        <= '0;
            oe_q          <= 1'b0;
            out_q         <= 1'b0;
            med_q         <= 1'b0;
            strong_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_lat_q  <= settle_lat_d;
            toggles_lat_q <= toggles_lat_d;
            mask_lat_q    <= mask_lat_d;
            remaining_q   <= remaining_d;
            code_q        <= code_d;
            level_q       <= level_d;
            tog_left_q    <= tog_left_d;
            settle_cnt_q  <= settle_cnt_d;
            err_q         <= err_d;
            pass_q        <= pass_d;
            sync_q        <= sync_d;
            oe_q          <= oe_d;
            out_q         <= out_d;
            med_q         <= med_d;
            strong_q      <= strong_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        settle_lat_d  = settle_lat_q;
        toggles_lat_d = toggles_lat_q;
        mask_lat_d    = mask_lat_q;
        remaining_d   = remaining_q;
        code_d        = code_q;
        level_d       = level_q;
        tog_left_d    = tog_left_q;
        settle_cnt_d  = settle_cnt_q;
        err_d         = err_q;
        pass_d        = pass_q;
        // Abort freezes all datapath state so partial counts survive.
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        settle_lat_d  = settle_i;
                        toggles_lat_d = toggles_i;
                        mask_lat_d    = mask_i;
                        remaining_d   = mask_i;
                        err_d         = '0;
                        pass_d        = '0;
                        state_d       = S_SEL;
                    end
                end
                S_SEL: begin
                    if (remaining_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        code_d       = low_idx;
                        remaining_d  = remaining_q & ~(4'd1 << low_idx);
                        level_d      = 1'b1;
                        tog_left_d   = (toggles_lat_q == 16'd0) ? 16'd1 : toggles_lat_q;
                        settle_cnt_d = settle_lat_q;
                        state_d      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (settle_cnt_q == 8'd0) state_d = S_SAMPLE;
                    else                      settle_cnt_d = settle_cnt_q - 8'd1;
                end
                S_SAMPLE: begin
                    if (sync_in != level_q && err_q[code_q] != {CNT_W{1'b1}})
                        err_d[code_q] = err_q[code_q] + CNT_W'(1);
                    level_d    = ~level_q;
                    tog_left_d = tog_left_q - 16'd1;
                    if (tog_left_q == 16'd1) begin
                        state_d = S_SEL;
                    end else begin
                        settle_cnt_d = settle_lat_q;
                        state_d      = S_WAIT;
                    end
                end
                S_DONE: begin
                    for (int k = 0; k < 4; k++)
                        pass_d[k] = mask_lat_q[k] & (err_q[k] == '0);
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so the pad moves on the entering edge.
    always_comb begin
        drive    = (state_d == S_WAIT) || (state_d == S_SAMPLE);
        oe_d     = drive;
        out_d    = drive & level_d;
        med_d    = drive & code_d[0];
        strong_d = drive & code_d[1];
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    assign pad.dut_oe_l_o          = oe_q;
    assign pad.dut_out_l_o         = out_q;
    assign pad.dut_med_enable_o    = med_q;
    assign pad.dut_strong_enable_o = strong_q;
    assign busy_o                  = busy_q;
    assign done_o                  = done_q;
    assign pass_o                  = pass_q;
    assign err_count_o             = err_q;
endmodule

// File: tb/tb_fastio_loopback_sequencer.sv
// Directed bench for the fastio loopback sequencer using a behavioural pad loopback.
module tb_fastio_loopback_sequencer;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [7:0]    settle;
    logic [15:0]   toggles;
    logic [3:0]    mask;
    logic          busy, done;
    logic [3:0]    pass;
    logic [4*CW-1:0] errc;
    logic [1:0]    lb_mode;   // 0 ideal, 1 tied low, 2 tied high

    int n_cmp = 0;
    int n_bad = 0;

    int          r_busy, r_done, r_done_at, r_nz;
    logic [15:0] r_trace;

    fastio_loopback_sequencer_if pif ();

    assign pif.fastio_in_i = (lb_mode == 2'd0) ? (pif.dut_oe_l_o & pif.dut_out_l_o)
                           : (lb_mode == 2'd2);

    fastio_loopback_sequencer #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .settle_i    (settle),
        .toggles_i   (toggles),
        .mask_i      (mask),
        .pad         (pif),
        .busy_o      (busy),
        .done_o      (done),
        .pass_o      (pass),
        .err_count_o (errc)
    );

    always #5 clk = ~clk;

    task automatic run_seq(input logic [3:0] m, input logic [7:0] s, input logic [15:0] t);
        logic prev_oe;
        @(negedge clk);
        start = 1'b1; mask = m; settle = s; toggles = t;
        @(posedge clk); #1;
        start = 1'b0;
        r_busy = 0; r_done = 0; r_done_at = 0; r_nz = 0; r_trace = '0; prev_oe = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            r_busy++;
            if (done) begin r_done++; r_done_at = r_busy; end
            if (pif.dut_oe_l_o && !prev_oe)
                r_trace = {r_trace[13:0], pif.dut_strong_enable_o, pif.dut_med_enable_o};
            if (pif.dut_oe_l_o && (pif.dut_med_enable_o || pif.dut_strong_enable_o)) r_nz++;
            prev_oe = pif.dut_oe_l_o;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL run_timeout busy=%b required 0", busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 0; abort = 0; mask = 0; settle = 0; toggles = 0; lb_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, pass, pif.dut_oe_l_o, pif.dut_out_l_o, pif.dut_med_enable_o,
             pif.dut_strong_enable_o} !== 10'b0) begin
            n_bad++; $display("FAIL reset_outputs got %b required 0", {busy, done, pass});
        end
        n_cmp++;
        if (errc !== '0) begin n_bad++; $display("FAIL reset_errc got %h required 0", errc); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_ideal_single();
        lb_mode = 0;
        run_seq(4'b0001, 8'd3, 16'd4);
        n_cmp++; if (r_busy !== 23) begin n_bad++; $display("FAIL single_busy got %0d required 23", r_busy); end
        n_cmp++; if (r_done !== 1 || r_done_at !== 23) begin
            n_bad++; $display("FAIL single_done count=%0d at=%0d required 1 at 23", r_done, r_done_at); end
        n_cmp++; if (errc[0 +: CW] !== 4'd0) begin n_bad++; $display("FAIL single_err got %0d required 0", errc[0 +: CW]); end
        n_cmp++; if (pass !== 4'b0001) begin n_bad++; $display("FAIL single_pass got %b required 0001", pass); end
        n_cmp++; if (r_nz !== 0) begin n_bad++; $display("FAIL single_strength got %0d nonzero cycles required 0", r_nz); end
    endtask

    task automatic test_all_codes();
        lb_mode = 0;
        run_seq(4'b1111, 8'd1, 16'd3);
        n_cmp++; if (r_busy !== 42) begin n_bad++; $display("FAIL all_busy got %0d required 42", r_busy); end
        n_cmp++; if (r_trace[7:0] !== 8'b00_01_10_11) begin
            n_bad++; $display("FAIL all_order got %b required 00011011", r_trace[7:0]); end
        n_cmp++; if (pass !== 4'b1111) begin n_bad++; $display("FAIL all_pass got %b required 1111", pass); end
        n_cmp++; if (errc !== '0) begin n_bad++; $display("FAIL all_err got %h required 0", errc); end
    endtask

    task automatic test_no_settle();
        lb_mode = 0;
        run_seq(4'b0001, 8'd0, 16'd10);
        n_cmp++; if (errc[0 +: CW] !== 4'd10) begin n_bad++; $display("FAIL nosettle_err got %0d required 10", errc[0 +: CW]); end
        n_cmp++; if (pass !== 4'b0000) begin n_bad++; $display("FAIL nosettle_pass got %b required 0000", pass); end
    endtask

    task automatic test_toggle_zero();
        lb_mode = 1;
        run_seq(4'b0100, 8'd2, 16'd0);
        n_cmp++; if (r_busy !== 7) begin n_bad++; $display("FAIL tog0_busy got %0d required 7", r_busy); end
        n_cmp++; if (errc !== 16'h0100) begin n_bad++; $display("FAIL tog0_err got %h required 0100", errc); end
        n_cmp++; if (pass !== 4'b0000) begin n_bad++; $display("FAIL tog0_pass got %b required 0000", pass); end
    endtask

    task automatic test_saturate();
        lb_mode = 2;
        run_seq(4'b0001, 8'd0, 16'd40);
        n_cmp++; if (r_busy !== 83) begin n_bad++; $display("FAIL sat_busy got %0d required 83", r_busy); end
        n_cmp++; if (errc[0 +: CW] !== 4'd15) begin n_bad++; $display("FAIL sat_err got %0d required 15", errc[0 +: CW]); end
        run_seq(4'b0000, 8'd5, 16'd5);
        n_cmp++; if (r_busy !== 2 || r_done_at !== 2) begin
            n_bad++; $display("FAIL empty_busy got %0d done_at %0d required 2/2", r_busy, r_done_at); end
        n_cmp++; if (errc !== '0) begin n_bad++; $display("FAIL empty_err got %h required 0", errc); end
        n_cmp++; if (pass !== 4'b0000) begin n_bad++; $display("FAIL empty_pass got %b required 0000", pass); end
    endtask

    task automatic test_abort_reset();
        int  seen_done;
        bit  found;
        lb_mode = 0; seen_done = 0; found = 0;
        @(negedge clk);
        start = 1; mask = 4'b0011; settle = 8'd3; toggles = 16'd2;
        @(negedge clk); start = 0;
        repeat (2) @(negedge clk);
        start = 1; mask = 4'b1000;          // must be ignored while busy
        @(negedge clk); start = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done) seen_done++;
            if (pif.dut_med_enable_o) begin found = 1; break; end
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL abort_reach_code1 got timeout required med=1"); end
        @(negedge clk); abort = 1;
        @(posedge clk); #1;
        if (done) seen_done++;
        n_cmp++; if (busy !== 1'b0 || pif.dut_oe_l_o !== 1'b0) begin
            n_bad++; $display("FAIL abort_idle busy=%b oe=%b required 0/0", busy, pif.dut_oe_l_o); end
        @(negedge clk); abort = 0;
        repeat (3) begin @(posedge clk); #1; if (done) seen_done++; end
        n_cmp++; if (seen_done !== 0) begin n_bad++; $display("FAIL abort_done got %0d pulses required 0", seen_done); end
        n_cmp++; if (pass !== 4'b0000 || errc !== '0) begin
            n_bad++; $display("FAIL abort_results pass=%b err=%h required 0000/0", pass, errc); end
        // start and abort together in IDLE: start wins
        @(negedge clk); start = 1; abort = 1; mask = 4'b0001; settle = 8'd2; toggles = 16'd3;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_abort_idle busy=%b required 1", busy); end
        @(negedge clk); start = 0; abort = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(posedge clk); #1;
        n_cmp++; if ({busy, done, pass, pif.dut_oe_l_o, pif.dut_out_l_o, pif.dut_med_enable_o,
                      pif.dut_strong_enable_o} !== 10'b0 || errc !== '0) begin
            n_bad++; $display("FAIL midrun_reset busy=%b oe=%b err=%h required all 0", busy, pif.dut_oe_l_o, errc); end
        @(negedge clk); rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_ideal_single();
        test_all_codes();
        test_no_settle();
        test_toggle_zero();
        test_saturate();
        test_abort_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
